// File: rtl/axi4_dram_wr_arbiter_if.sv
// ---------------------------------------------------------------------------
// axi4_dram_wr_arbiter_if
// Purpose : One AXI4 write path (AW, W and B channels). Used for both
//           requester ports and for the DRAM-side port of the write arbiter.
// Signals : awid/awaddr/awlen/awsize/awburst/awvalid/awready  - address channel
//           wdata/wstrb/wlast/wvalid/wready                   - write data channel
//           bid/bresp/bvalid/bready                           - write response channel
// Modports: master - drives AW/W and BREADY (the side that issues writes)
//           slave  - drives AWREADY/WREADY and the B channel
// ---------------------------------------------------------------------------
interface axi4_dram_wr_arbiter_if #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH = 4
);
    logic [AXI4_ID_WIDTH-1:0]  awid;
    logic [ADDR_WIDTH-1:0]     awaddr;
    logic [7:0]                awlen;
    logic [2:0]                awsize;
    logic [1:0]                awburst;
    logic                      awvalid;
    logic                      awready;

    logic [DATA_WIDTH-1:0]     wdata;
    logic [DATA_WIDTH/8-1:0]   wstrb;
    logic                      wlast;
    logic                      wvalid;
    logic                      wready;

    logic [AXI4_ID_WIDTH-1:0]  bid;
    logic [1:0]                bresp;
    logic                      bvalid;
    logic                      bready;

    modport master (
        output awid, awaddr, awlen, awsize, awburst, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  awid, awaddr, awlen, awsize, awburst, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi4_dram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// axi4_dram_wr_arbiter
// Purpose : Shares the single DRAM AXI4 write path between requester S0
//           (RISC-V) and requester S1 (systolic array). Round-robin
//           arbitration, exactly one write burst in flight at a time.
// Ports   : clk          - clock, all logic on the rising edge
//           rst          - asynchronous active-high reset
//           i_s0, i_s1   - requester write ports (slave modport)
//           o_m          - DRAM write port (master modport), AW registered,
//                          W and B combinational pass-through of the grantee
//           o_wlast_err  - one-cycle pulse when a requester's WLAST disagrees
//                          with the beat count implied by its AWLEN
// ---------------------------------------------------------------------------
module axi4_dram_wr_arbiter #(
    parameter int ADDR_WIDTH    = 32,
    parameter int DATA_WIDTH    = 32,
    parameter int AXI4_ID_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    axi4_dram_wr_arbiter_if.slave  i_s0,
    axi4_dram_wr_arbiter_if.slave  i_s1,
    axi4_dram_wr_arbiter_if.master o_m,
    output logic                   o_wlast_err
);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t                   r_state;
    logic                     r_grant;
    logic                     r_lastGrant;
    logic [AXI4_ID_WIDTH-1:0] r_awid;
    logic [ADDR_WIDTH-1:0]    r_awaddr;
    logic [7:0]               r_awlen;
    logic [2:0]               r_awsize;
    logic [1:0]               r_awburst;
    logic                     r_awvalid;
    logic [7:0]               r_beat;
    logic                     r_wlastErr;

    logic                     w_idle;
    logic                     w_inData;
    logic                     w_inResp;
    logic                     w_pickS1;
    logic                     w_accept;
    logic                     w_beatLast;
    logic                     w_selWvalid;
    logic                     w_selWlast;
    logic [DATA_WIDTH-1:0]    w_wdata;
    logic [DATA_WIDTH/8-1:0]  w_wstrb;
    logic                     w_selBready;
    logic                     w_wHs;
    logic                     w_bHs;

    // AWREADY is combinational, so it is masked while reset is held to keep
    // every READY output low during reset even if a requester is asserting AWVALID.
    assign w_idle   = (r_state == IDLE) && !rst;
    assign w_inData = (r_state == DATA);
    assign w_inResp = (r_state == RESP);

    // S1 wins when it is the only requester, or on a tie when S0 had the last grant.
    assign w_pickS1 = i_s1.awvalid && (!i_s0.awvalid || !r_lastGrant);
    assign w_accept = w_idle && (i_s0.awvalid || i_s1.awvalid);

    assign i_s0.awready = w_idle && i_s0.awvalid && !w_pickS1;
    assign i_s1.awready = w_idle && w_pickS1;

    assign o_m.awid     = r_awid;
    assign o_m.awaddr   = r_awaddr;
    assign o_m.awlen    = r_awlen;
    assign o_m.awsize   = r_awsize;
    assign o_m.awburst  = r_awburst;
    assign o_m.awvalid  = r_awvalid;

    // W channel: grantee passes straight through; WLAST comes from our own
    // beat count so a misbehaving requester cannot change the burst length.
    assign w_beatLast  = (r_beat == r_awlen);
    assign w_selWvalid = r_grant ? i_s1.wvalid : i_s0.wvalid;
    assign w_selWlast  = r_grant ? i_s1.wlast  : i_s0.wlast;
    assign w_wdata     = r_grant ? i_s1.wdata  : i_s0.wdata;
    assign w_wstrb     = r_grant ? i_s1.wstrb  : i_s0.wstrb;

    assign o_m.wdata   = w_wdata;
    assign o_m.wstrb   = w_wstrb;
    assign o_m.wvalid  = w_inData && w_selWvalid;
    assign o_m.wlast   = w_inData && w_beatLast;
    assign i_s0.wready = w_inData && !r_grant && o_m.wready;
    assign i_s1.wready = w_inData &&  r_grant && o_m.wready;
    assign w_wHs       = o_m.wvalid && o_m.wready;

    // B channel: only the grantee ever sees BVALID; ID and response pass through.
    assign w_selBready = r_grant ? i_s1.bready : i_s0.bready;
    assign o_m.bready  = w_inResp && w_selBready;
    assign i_s0.bvalid = w_inResp && !r_grant && o_m.bvalid;
    assign i_s1.bvalid = w_inResp &&  r_grant && o_m.bvalid;
    assign i_s0.bid    = o_m.bid;
    assign i_s1.bid    = o_m.bid;
    assign i_s0.bresp  = o_m.bresp;
    assign i_s1.bresp  = o_m.bresp;
    assign w_bHs       = o_m.bvalid && o_m.bready;

    assign o_wlast_err = r_wlastErr;

    // Burst sequencer: IDLE -> ADDR -> DATA -> RESP -> IDLE. lastGrant resets
    // to S1 so that S0 wins the very first tie.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_grant     <= 1'b0;
            r_lastGrant <= 1'b1;
            r_awid      <= '0;
            r_awaddr    <= '0;
            r_awlen     <= '0;
            r_awsize    <= '0;
            r_awburst   <= '0;
            r_awvalid   <= 1'b0;
            r_beat      <= '0;
            r_wlastErr  <= 1'b0;
        end else begin
            r_wlastErr <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        r_grant   <= w_pickS1;
                        r_awid    <= w_pickS1 ? i_s1.awid    : i_s0.awid;
                        r_awaddr  <= w_pickS1 ? i_s1.awaddr  : i_s0.awaddr;
                        r_awlen   <= w_pickS1 ? i_s1.awlen   : i_s0.awlen;
                        r_awsize  <= w_pickS1 ? i_s1.awsize  : i_s0.awsize;
                        r_awburst <= w_pickS1 ? i_s1.awburst : i_s0.awburst;
                        r_awvalid <= 1'b1;
                        r_state   <= ADDR;
                    end
                end
                ADDR: begin
                    if (o_m.awready) begin
                        r_awvalid <= 1'b0;
                        r_beat    <= '0;
                        r_state   <= DATA;
                    end
                end
                DATA: begin
                    if (w_wHs) begin
                        r_beat <= r_beat + 8'd1;
                        if (w_selWlast != w_beatLast) begin
                            r_wlastErr <= 1'b1;
                        end
                        if (w_beatLast) begin
                            r_state <= RESP;
                        end
                    end
                end
                RESP: begin
                    if (w_bHs) begin
                        r_lastGrant <= r_grant;
                        r_state     <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi4_dram_wr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_axi4_dram_wr_arbiter
// Purpose : Directed self-checking bench for axi4_dram_wr_arbiter. Requests
//           are pushed into per-requester queues when driven and popped when
//           the DRAM side presents the burst; the bench plays the DRAM.
// ---------------------------------------------------------------------------
module tb_axi4_dram_wr_arbiter;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam int IW = 4;

    typedef struct {
        logic [IW-1:0] id;
        logic [AW-1:0] addr;
        logic [7:0]    len;
    } awExp_t;

    logic clk = 1'b0;
    logic rst;
    logic wlastErr;

    awExp_t q0[$];
    awExp_t q1[$];

    int checks    = 0;
    int passes    = 0;
    int fails     = 0;
    int errPulses = 0;

    axi4_dram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) s0Bus ();
    axi4_dram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) s1Bus ();
    axi4_dram_wr_arbiter_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) mBus ();

    axi4_dram_wr_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI4_ID_WIDTH(IW)) dut (
        .clk         (clk),
        .rst         (rst),
        .i_s0        (s0Bus),
        .i_s1        (s1Bus),
        .o_m         (mBus),
        .o_wlast_err (wlastErr)
    );

    // 100 MHz clock
    always #5 clk = ~clk;

    // Count every cycle in which the WLAST error pulse is high.
    always @(negedge clk) begin
        if (wlastErr === 1'b1) errPulses++;
    end

    // One comparison: bumps the totals and reports any disagreement.
    task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else begin
            fails++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Drive one AW request on a requester and record what the DRAM should see.
    task automatic applyStimulus(input int which, input logic [IW-1:0] id,
                                 input logic [AW-1:0] addr, input logic [7:0] len);
        awExp_t e;
        e.id   = id;
        e.addr = addr;
        e.len  = len;
        if (which == 0) begin
            s0Bus.awvalid = 1'b1; s0Bus.awid = id; s0Bus.awaddr = addr;
            s0Bus.awlen = len; s0Bus.awsize = 3'd2; s0Bus.awburst = 2'd1;
            q0.push_back(e);
        end else begin
            s1Bus.awvalid = 1'b1; s1Bus.awid = id; s1Bus.awaddr = addr;
            s1Bus.awlen = len; s1Bus.awsize = 3'd2; s1Bus.awburst = 2'd1;
            q1.push_back(e);
        end
    endtask

    function automatic logic [DW-1:0] beatData(input awExp_t e, input int b);
        return {e.addr[15:0], 4'h0, e.id, 8'(b)};
    endfunction

    task automatic driveW(input int which, input logic v, input logic [DW-1:0] d,
                          input logic [DW/8-1:0] s, input logic l);
        if (which == 0) begin
            s0Bus.wvalid = v; s0Bus.wdata = d; s0Bus.wstrb = s; s0Bus.wlast = l;
        end else begin
            s1Bus.wvalid = v; s1Bus.wdata = d; s1Bus.wstrb = s; s1Bus.wlast = l;
        end
    endtask

    // Full burst from AW accept to B handshake, entered one delta after a
    // rising edge with the requests already driven.
    task automatic runBurst(input int expWinner, input bit toggleReady, input int bStall,
                            input bit earlyLast, input bit watchS0);
        awExp_t e;
        int beat;
        int cyc;
        int errBefore;
        logic [IW-1:0] grBid;
        logic [1:0]    grBresp;
        errBefore = errPulses;
        e = (expWinner == 1) ? q1.pop_front() : q0.pop_front();

        #1;
        checkOutput("awreadyWinner", (expWinner == 1) ? s1Bus.awready : s0Bus.awready, 1);
        checkOutput("awreadyLoser",  (expWinner == 1) ? s0Bus.awready : s1Bus.awready, 0);
        @(posedge clk); #1;
        if (expWinner == 1) s1Bus.awvalid = 1'b0; else s0Bus.awvalid = 1'b0;
        #1;
        checkOutput("mAwvalid", mBus.awvalid, 1);
        checkOutput("mAwid",    mBus.awid,    e.id);
        checkOutput("mAwaddr",  mBus.awaddr,  e.addr);
        checkOutput("mAwlen",   mBus.awlen,   e.len);
        checkOutput("mAwsize",  mBus.awsize,  3'd2);
        checkOutput("mAwburst", mBus.awburst, 2'd1);
        @(posedge clk); #1;
        mBus.awready = 1'b1;
        #1;
        checkOutput("mAwvalidHeld",  mBus.awvalid, 1);
        checkOutput("mAwaddrStable", mBus.awaddr,  e.addr);
        @(posedge clk); #1;
        mBus.awready = 1'b0;

        beat = 0;
        cyc  = 0;
        while (beat <= int'(e.len) && cyc < 1200) begin
            driveW(expWinner, 1'b1, beatData(e, beat), 4'(beat) | 4'h1,
                   (beat == int'(e.len)) || (earlyLast && beat == 0));
            mBus.wready = toggleReady ? (cyc % 2 == 0) : 1'b1;
            #1;
            if (cyc == 0) checkOutput("mAwvalidDrop", mBus.awvalid, 0);
            checkOutput("otherWready", (expWinner == 1) ? s0Bus.wready : s1Bus.wready, 0);
            if (watchS0) checkOutput("s0Blocked", s0Bus.awready, 0);
            if (mBus.wready) begin
                checkOutput("mWvalid", mBus.wvalid, 1);
                checkOutput("mWdata",  mBus.wdata,  beatData(e, beat));
                checkOutput("mWstrb",  mBus.wstrb,  4'(beat) | 4'h1);
                checkOutput("mWlast",  mBus.wlast,  beat == int'(e.len));
                checkOutput("grantWready", (expWinner == 1) ? s1Bus.wready : s0Bus.wready, 1);
                beat++;
            end else begin
                checkOutput("grantWreadyLow", (expWinner == 1) ? s1Bus.wready : s0Bus.wready, 0);
            end
            cyc++;
            @(posedge clk); #1;
        end
        checkOutput("beatCount", beat, int'(e.len) + 1);

        // Requester keeps WVALID up: nothing further may reach the DRAM.
        mBus.wready  = 1'b1;
        mBus.bvalid  = 1'b1;
        mBus.bid     = e.id;
        mBus.bresp   = e.addr[13:12];
        #1;
        checkOutput("noExtraBeat",   mBus.wvalid, 0);
        checkOutput("noExtraWready", (expWinner == 1) ? s1Bus.wready : s0Bus.wready, 0);
        checkOutput("mBreadyStall",  mBus.bready, 0);
        @(posedge clk); #1;
        driveW(expWinner, 1'b0, '0, '0, 1'b0);
        mBus.wready = 1'b0;
        for (int k = 0; k < bStall; k++) begin
            #1;
            checkOutput("bvalidGrant", (expWinner == 1) ? s1Bus.bvalid : s0Bus.bvalid, 1);
            checkOutput("bvalidOther", (expWinner == 1) ? s0Bus.bvalid : s1Bus.bvalid, 0);
            checkOutput("mBreadyHeld", mBus.bready, 0);
            if (watchS0) checkOutput("s0BlockedResp", s0Bus.awready, 0);
            @(posedge clk); #1;
        end
        if (expWinner == 1) s1Bus.bready = 1'b1; else s0Bus.bready = 1'b1;
        #1;
        grBid   = (expWinner == 1) ? s1Bus.bid   : s0Bus.bid;
        grBresp = (expWinner == 1) ? s1Bus.bresp : s0Bus.bresp;
        checkOutput("mBready",     mBus.bready, 1);
        checkOutput("bvalidRoute", (expWinner == 1) ? s1Bus.bvalid : s0Bus.bvalid, 1);
        checkOutput("bvalidOff",   (expWinner == 1) ? s0Bus.bvalid : s1Bus.bvalid, 0);
        checkOutput("bid",         grBid,   e.id);
        checkOutput("bresp",       grBresp, e.addr[13:12]);
        @(posedge clk); #1;
        mBus.bvalid   = 1'b0;
        s0Bus.bready  = 1'b0;
        s1Bus.bready  = 1'b0;
        checkOutput("wlastErrPulses", errPulses - errBefore, earlyLast ? 1 : 0);
    endtask

    initial begin
        awExp_t ab;
        rst = 1'b1;
        s0Bus.awvalid = 0; s0Bus.awid = 0; s0Bus.awaddr = 0; s0Bus.awlen = 0;
        s0Bus.awsize = 0; s0Bus.awburst = 0; s0Bus.bready = 0;
        s1Bus.awvalid = 0; s1Bus.awid = 0; s1Bus.awaddr = 0; s1Bus.awlen = 0;
        s1Bus.awsize = 0; s1Bus.awburst = 0; s1Bus.bready = 0;
        driveW(0, 1'b0, '0, '0, 1'b0);
        driveW(1, 1'b0, '0, '0, 1'b0);
        mBus.awready = 0; mBus.wready = 0; mBus.bvalid = 0; mBus.bid = 0; mBus.bresp = 0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        #1;

        // Idle after reset: every handshake output low.
        $display("[TB] reset and idle");
        checkOutput("rstS0Awready", s0Bus.awready, 0);
        checkOutput("rstS1Awready", s1Bus.awready, 0);
        checkOutput("rstS0Wready",  s0Bus.wready,  0);
        checkOutput("rstS1Wready",  s1Bus.wready,  0);
        checkOutput("rstS0Bvalid",  s0Bus.bvalid,  0);
        checkOutput("rstS1Bvalid",  s1Bus.bvalid,  0);
        checkOutput("rstMAwvalid",  mBus.awvalid,  0);
        checkOutput("rstMWvalid",   mBus.wvalid,   0);
        checkOutput("rstMBready",   mBus.bready,   0);
        checkOutput("rstWlastErr",  wlastErr,      0);
        @(posedge clk); #1;
        applyStimulus(0, 4'h3, 32'h0000_0100, 8'd0);
        runBurst(0, 1'b0, 0, 1'b0, 1'b0);

        // Fresh reset so that S0 again owns the first tie.
        $display("[TB] round-robin ties");
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (!s0Bus.awvalid) applyStimulus(0, 4'(i), 32'h1000 + 32'(i) * 32'h40, 8'(i % 2));
            if (!s1Bus.awvalid) applyStimulus(1, 4'(8 + i), 32'h2000 + 32'(i) * 32'h40, 8'd1);
            runBurst(i % 2, 1'b0, 0, 1'b0, 1'b0);
        end
        runBurst(0, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] S1 burst with toggling DRAM WREADY");
        applyStimulus(1, 4'h5, 32'h0000_3000, 8'd3);
        runBurst(1, 1'b1, 0, 1'b0, 1'b0);

        $display("[TB] early WLAST from S0");
        applyStimulus(0, 4'h6, 32'h0000_4000, 8'd1);
        runBurst(0, 1'b0, 0, 1'b1, 1'b0);

        $display("[TB] B stall holds off S0");
        applyStimulus(1, 4'h7, 32'h0000_5000, 8'd2);
        applyStimulus(0, 4'h8, 32'h0000_6000, 8'd0);
        runBurst(1, 1'b0, 5, 1'b0, 1'b1);
        runBurst(0, 1'b0, 0, 1'b0, 1'b0);

        $display("[TB] reset in the middle of a burst");
        applyStimulus(0, 4'h9, 32'h0000_7000, 8'd7);
        ab = q0.pop_front();
        #1;
        checkOutput("abortAwready", s0Bus.awready, 1);
        @(posedge clk); #1;
        s0Bus.awvalid = 1'b0;
        mBus.awready  = 1'b1;
        @(posedge clk); #1;
        mBus.awready  = 1'b0;
        driveW(0, 1'b1, beatData(ab, 0), 4'hF, 1'b0);
        mBus.wready = 1'b1;
        #1;
        checkOutput("abortMWvalid",  mBus.wvalid,  1);
        checkOutput("abortS0Wready", s0Bus.wready, 1);
        rst = 1'b1;
        #1;
        checkOutput("asyncMWvalid",  mBus.wvalid,  0);
        checkOutput("asyncS0Wready", s0Bus.wready, 0);
        checkOutput("asyncMAwvalid", mBus.awvalid, 0);
        checkOutput("asyncWlastErr", wlastErr,     0);
        applyStimulus(0, 4'hA, 32'h0000_8000, 8'd2);
        applyStimulus(1, 4'hB, 32'h0000_9000, 8'd255);
        driveW(0, 1'b0, '0, '0, 1'b0);
        mBus.wready = 1'b0;
        #1;
        checkOutput("rstHeldS0Awready", s0Bus.awready, 0);
        checkOutput("rstHeldS1Awready", s1Bus.awready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        runBurst(0, 1'b0, 0, 1'b0, 1'b0);
        runBurst(1, 1'b0, 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
